wb_regfile: RTL and testbench

Write-back stage and architectural register file of the pipelined CPU. It consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result, load data or PC+4), and commits it to a 32×32-bit register file. It also serves the two decode-stage read ports. Same-cycle write→read bypass is built in so decode sees the value being retired.

---
 rtl/wb_regfile_pkg.sv | 20 ++
 rtl/wb_regfile_wb_mux.sv | 30 +++
 rtl/wb_regfile.sv | 107 ++++++++++
 tb/tb_wb_regfile.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
// Shared encodings for the write-back stage and register file.
//   WB_* : write-back source select codes (nnns_data_write)
//   REG_ZERO : index of the hard-wired zero register
//   wb_is_commit : write enable qualified by a non-zero destination
package wb_regfile_pkg;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_RSV   = 2'b11;  // reserved code, behaves as ALU

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A write only lands when enabled and not aimed at the zero register.
  function automatic logic wb_is_commit(input logic i_we, input logic [4:0] i_rd);
    return i_we && (i_rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// wb_mux
// Pure combinational write-back source selector.
//   i_sel  : source select (ALU / load data / PC+4, reserved code -> ALU)
//   i_alu  : ALU result
//   i_mem  : load data
//   i_pc4  : link value (PC+4)
//   o_data : selected write-back value
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_data
);

  // Source selection; the reserved code and any unknown select fall back to ALU.
  always_comb begin
    o_data = i_alu;
    case (i_sel)
      WB_ALU:  o_data = i_alu;
      WB_MEM:  o_data = i_mem;
      WB_PC4:  o_data = i_pc4;
      WB_RSV:  o_data = i_alu;
      default: o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
// Write-back stage plus 32x32 architectural register file with two
// combinational read ports and same-cycle write->read bypass.
//   clock, reset            : system clock, synchronous active-high reset
//   ddpc4, dbusw, ddata     : write-back candidates (PC+4, ALU, load data)
//   drw, nnnreg_write       : destination index and write enable
//   nnns_data_write         : write-back source select
//   ra, rb / busa, busb     : decode read ports
//   wb_data                 : selected write-back value (combinational)
//   retire_cnt              : number of committed register writes
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ddpc4,
  input  logic [31:0] dbusw,
  input  logic [31:0] ddata,
  input  logic [4:0]  drw,
  input  logic        nnnreg_write,
  input  logic [1:0]  nnns_data_write,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] busa,
  output logic [31:0] busb,
  output logic [31:0] wb_data,
  output logic [31:0] retire_cnt
);

  // Register 0 has no storage; it is synthesised as a constant on read.
  logic [31:0] r_regs [1:31];
  logic [31:0] r_retire_cnt;
  logic [31:0] w_wb_data;
  logic        w_commit;
  logic [31:0] w_rega;
  logic [31:0] w_regb;

  wb_mux u_wb_mux (
    .i_sel  (nnns_data_write),
    .i_alu  (dbusw),
    .i_mem  (ddata),
    .i_pc4  (ddpc4),
    .o_data (w_wb_data)
  );

  assign w_commit   = wb_is_commit(nnnreg_write, drw);
  assign wb_data    = w_wb_data;
  assign retire_cnt = r_retire_cnt;

  // Register array and retire counter; reset wins over a same-cycle commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
      r_retire_cnt <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_commit && (drw == i[4:0])) begin
          r_regs[i] <= w_wb_data;
        end
      end
      if (w_commit) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  // Raw array lookup for both ports; index 0 matches no entry and yields zero.
  always_comb begin
    w_rega = 32'd0;
    w_regb = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (ra == i[4:0]) begin
        w_rega = r_regs[i];
      end else begin
        w_rega = w_rega;
      end
      if (rb == i[4:0]) begin
        w_regb = r_regs[i];
      end else begin
        w_regb = w_regb;
      end
    end
  end

  // Read ports with bypass so decode sees the value retiring this cycle.
  always_comb begin
    busa = w_rega;
    busb = w_regb;
    if (ra == REG_ZERO) begin
      busa = 32'd0;
    end else if (w_commit && (ra == drw)) begin
      busa = w_wb_data;
    end else begin
      busa = w_rega;
    end
    if (rb == REG_ZERO) begin
      busb = 32'd0;
    end else if (w_commit && (rb == drw)) begin
      busb = w_wb_data;
    end else begin
      busb = w_regb;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ddpc4, dbusw, ddata;
  logic [4:0]  drw, ra, rb;
  logic        nnnreg_write;
  logic [1:0]  nnns_data_write;
  logic [31:0] busa, busb, wb_data, retire_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_regs [0:31];
  logic [31:0] m_cnt;
  bit          m_ok = 1'b0;

  wb_regfile dut (
    .clock(clock), .reset(reset), .ddpc4(ddpc4), .dbusw(dbusw), .ddata(ddata),
    .drw(drw), .nnnreg_write(nnnreg_write), .nnns_data_write(nnns_data_write),
    .ra(ra), .rb(rb), .busa(busa), .busb(busb), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wb();
    if (nnns_data_write == 2'd1) return ddata;
    if (nnns_data_write == 2'd2) return ddpc4;
    return dbusw;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (nnnreg_write && drw != 5'd0 && idx == drw) return m_wb();
    return m_regs[idx];
  endfunction

  // Model update at each rising edge from the inputs held stable across it
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      m_ok  = 1'b1;
    end else if (m_ok && nnnreg_write && drw != 5'd0) begin
      m_regs[drw] = m_wb();
      m_cnt = m_cnt + 32'd1;
    end
  end

  // Compare process: every falling edge once the model is defined
  always @(negedge clock) begin
    if (m_ok) begin
      chk("wb_data", wb_data, m_wb());
      chk("busa", busa, m_read(ra));
      chk("busb", busb, m_read(rb));
      chk("retire_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
    nnnreg_write = we; nnns_data_write = sel; drw = rd;
    dbusw = alu; ddata = mem; ddpc4 = pc4;
  endtask

  initial begin
    reset = 1'b1;
    set(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    ra = 5'd0; rb = 5'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    ra = 5'd5; rb = 5'd31; #1;
    chk("reset_busa", busa, 32'h0000_0000);
    chk("reset_busb", busb, 32'h0000_0000);
    chk("reset_cnt", retire_cnt, 32'h0000_0000);

    // Source select sweep into r5, with bypass visible before each edge
    tick();
    ra = 5'd5; rb = 5'd5;
    set(1'b1, 2'b00, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h0040_0008); #1;
    chk("sel00_bypass", busa, 32'h1111_1111);
    tick();
    set(1'b1, 2'b01, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h0040_0008); #1;
    chk("sel01_bypass", busb, 32'h2222_2222);
    tick();
    set(1'b1, 2'b10, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h0040_0008); #1;
    chk("sel10_wbdata", wb_data, 32'h0040_0008);
    chk("sel10_prev_r5", retire_cnt, 32'd2);
    tick();
    set(1'b1, 2'b11, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h0040_0008); #1;
    chk("sel11_bypass", busa, 32'h1111_1111);
    tick();
    set(1'b0, 2'b01, 5'd5, 32'h0, 32'h0, 32'h0); #1;
    chk("sel_final_r5", busa, 32'h1111_1111);
    chk("sel_cnt4", retire_cnt, 32'd4);

    // Zero register write is discarded and not counted
    set(1'b1, 2'b00, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    ra = 5'd0; #1;
    chk("zero_busa", busa, 32'h0000_0000);
    chk("zero_wbdata", wb_data, 32'hDEAD_BEEF);
    tick();
    set(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0); #1;
    chk("zero_cnt", retire_cnt, 32'd4);

    // Dual-port bypass
    set(1'b1, 2'b01, 5'd7, 32'h0, 32'hCAFE_0001, 32'h0);
    ra = 5'd7; rb = 5'd7; #1;
    chk("byp_busa", busa, 32'hCAFE_0001);
    chk("byp_busb", busb, 32'hCAFE_0001);
    tick();
    set(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0); #1;
    chk("byp_stored", busa, 32'hCAFE_0001);
    chk("byp_cnt", retire_cnt, 32'd5);

    // Write disabled
    set(1'b0, 2'b00, 5'd3, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    ra = 5'd3; #1;
    chk("wdis_bypass_off", busa, 32'h0000_0000);
    tick(); #1;
    chk("wdis_r3", busa, 32'h0000_0000);
    chk("wdis_cnt", retire_cnt, 32'd5);

    // Randomised traffic with occasional reset; compare process does the checking
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      set($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
          $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        ra = drw;
      end else begin
        ra = 5'($urandom_range(0, 31));
      end
      rb = ($urandom_range(0, 3) == 0) ? drw : 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0;

    // Reset beats a same-cycle commit
    set(1'b1, 2'b00, 5'd9, 32'h0000_0123, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    ra = 5'd9; rb = 5'd9; #1;
    chk("rst_vs_commit_r9", busa, 32'h0000_0000);
    chk("rst_vs_commit_cnt", retire_cnt, 32'h0000_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
